// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Scans a 4-digit multiplexed 7-segment display for the stopwatch. Each digit
// owns a slot of DIV clocks; the first BLANK clocks of every slot keep the
// digit strobe low so the previous digit's segments never ghost onto the next.
// The BCD digits are captured once per frame, on the 3->0 wrap, so a value
// that changes mid-frame cannot tear across digits.
//
// Parameters
//   DIV     clocks per digit slot (>= 2)
//   BLANK   strobe-low clocks at the start of each slot (0..DIV-1)
//   DP_POS  digit index (0..3) whose decimal point is lit
//
// Optional feature (compile-time macro)
//   LZB_EN  leading-zero blanking: when defined, the digit-3 strobe is
//           suppressed while the snapped minute-tens digit is zero.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   display enable
//   digits_i   in   16  BCD digits, [3:0]=d0 (sec ones) .. [15:12]=d3
//   sel        out  2   digit select to the demux
//   act        out  1   digit strobe to the demux
//   digit_bcd  out  4   BCD of the selected digit (from the frame snapshot)
//   dp         out  1   decimal point of the selected digit
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int DIV    = 50000,
    parameter int BLANK  = 4,
    parameter int DP_POS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits_i,
    output logic [1:0]  sel,
    output logic        act,
    output logic [3:0]  digit_bcd,
    output logic        dp
);

    localparam int             PW      = $clog2(DIV);
    localparam logic [PW-1:0]  LAST    = PW'(DIV - 1);
    localparam logic [PW-1:0]  ONE     = PW'(1);
    localparam logic [1:0]     DP_SEL  = 2'(DP_POS);

    logic          en_q;
    logic [PW-1:0] presc;
    logic [1:0]    sel_q;
    logic [15:0]   snap;

    logic          slot_end;
    logic          in_gap;
    logic          lzb_kill;

    assign slot_end = (presc == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            presc <= '0;
            sel_q <= 2'd0;
            snap  <= 16'h0000;
        end else begin
            en_q <= en;
            if (!en_q) begin
                // Idle: hold the scan at digit 0 and keep the snapshot live so
                // the first slot after start shows the newest value.
                presc <= '0;
                sel_q <= 2'd0;
                snap  <= digits_i;
            end else if (slot_end) begin
                presc <= '0;
                sel_q <= sel_q + 2'd1;
                // Frame boundary: capture together with the 3->0 wrap.
                if (sel_q == 2'd3) begin
                    snap <= digits_i;
                end
            end else begin
                presc <= presc + ONE;
            end
        end
    end

    // Blanking window at the start of each slot. With BLANK=0 there is no
    // window, and the compare is elided rather than left as a constant test.
    generate
        if (BLANK == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            localparam logic [PW-1:0] BLANK_W = PW'(BLANK);
            assign in_gap = (presc < BLANK_W);
        end
    endgenerate

`ifdef LZB_EN
    // Slot timing is kept; only the strobe for a leading zero is dropped.
    assign lzb_kill = (sel_q == 2'd3) && (snap[15:12] == 4'd0);
`else
    assign lzb_kill = 1'b0;
`endif

    assign sel = sel_q;
    assign act = en_q && !in_gap && !lzb_kill;
    assign dp  = en_q && (sel_q == DP_SEL);

    always_comb begin
        digit_bcd = snap[3:0];
        case (sel_q)
            2'd0: digit_bcd = snap[3:0];
            2'd1: digit_bcd = snap[7:4];
            2'd2: digit_bcd = snap[11:8];
            2'd3: digit_bcd = snap[15:12];
            default: digit_bcd = snap[3:0];
        endcase
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_i;
    logic [1:0]  sel;
    logic        act;
    logic [3:0]  digit_bcd;
    logic        dp;

    int pass_cnt;
    int total_cnt;

    display_scan_ctrl #(
        .DIV    (4),
        .BLANK  (1),
        .DP_POS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits_i  (digits_i),
        .sel       (sel),
        .act       (act),
        .digit_bcd (digit_bcd),
        .dp        (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for cycle k of a run with DIV=4, BLANK=1, DP_POS=2,
    // where val is the frame snapshot being displayed.
    task automatic check_run(input string phase, input int k, input logic [15:0] val);
        int         pos;
        logic [1:0] s;
        logic       a;
        logic [3:0] d;
        pos = k % 4;
        s   = 2'((k / 4) % 4);
        a   = (pos != 0);
`ifdef LZB_EN
        if (s == 2'd3 && val[15:12] == 4'd0) a = 1'b0;
`endif
        case (s)
            2'd0: d = val[3:0];
            2'd1: d = val[7:4];
            2'd2: d = val[11:8];
            default: d = val[15:12];
        endcase
        $display("%s k=%0d sel=%0d act=%0b digit=%0h dp=%0b", phase, k, sel, act, digit_bcd, dp);
        check({phase, "_sel"},   16'(sel),       16'(s));
        check({phase, "_act"},   16'(act),       16'(a));
        check({phase, "_digit"}, 16'(digit_bcd), 16'(d));
        check({phase, "_dp"},    16'(dp),        16'(s == 2'd2));
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b1;
        en        = 1'b0;
        digits_i  = 16'h1234;

        // Reset state, applied between clock edges.
        #2 rst_n = 1'b0;
        #1;
        $display("reset sel=%0d act=%0b digit=%0h dp=%0b", sel, act, digit_bcd, dp);
        check("rst_sel",   16'(sel),       16'd0);
        check("rst_act",   16'(act),       16'd0);
        check("rst_digit", 16'(digit_bcd), 16'd0);
        check("rst_dp",    16'(dp),        16'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle: snapshot tracks digits_i, no strobe.
        tick();
        $display("idle sel=%0d act=%0b digit=%0h dp=%0b", sel, act, digit_bcd, dp);
        check("idle_sel",   16'(sel),       16'd0);
        check("idle_act",   16'(act),       16'd0);
        check("idle_digit", 16'(digit_bcd), 16'h4);

        // Run: two frames; digits change in slot 1 of the first frame and
        // must only appear in the second frame.
        en = 1'b1;
        for (int k = 0; k < 42; k++) begin
            tick();
            check_run("run1", k, (k < 16) ? 16'h1234 : 16'h5678);
            if (k == 5) digits_i = 16'h5678;
        end

        // Drop en in slot 2 (k=41): strobe and dp fall after the next edge,
        // select stays at 2 for that cycle, then clears.
        en = 1'b0;
        tick();
        $display("stop1 sel=%0d act=%0b digit=%0h dp=%0b", sel, act, digit_bcd, dp);
        check("stop1_sel",   16'(sel),       16'd2);
        check("stop1_act",   16'(act),       16'd0);
        check("stop1_dp",    16'(dp),        16'd0);
        check("stop1_digit", 16'(digit_bcd), 16'h6);
        digits_i = 16'h0159;
        tick();
        $display("stop2 sel=%0d act=%0b digit=%0h dp=%0b", sel, act, digit_bcd, dp);
        check("stop2_sel",   16'(sel),       16'd0);
        check("stop2_act",   16'(act),       16'd0);
        check("stop2_dp",    16'(dp),        16'd0);
        check("stop2_digit", 16'(digit_bcd), 16'h9);

        // Restart with a leading zero in digit 3; run into slot 2 of frame 2.
        en = 1'b1;
        for (int k = 0; k < 26; k++) begin
            tick();
            check_run("run2", k, 16'h0159);
        end

        // Asynchronous reset mid-slot: outputs clear before any clock edge.
        rst_n = 1'b0;
        #1;
        $display("mid_rst sel=%0d act=%0b digit=%0h dp=%0b", sel, act, digit_bcd, dp);
        check("mrst_sel",   16'(sel),       16'd0);
        check("mrst_act",   16'(act),       16'd0);
        check("mrst_digit", 16'(digit_bcd), 16'd0);
        check("mrst_dp",    16'(dp),        16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
